// File: rtl/fadd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fadd_arbiter
// Brief    : Round-robin sequencer sharing one non-pipelined float adder among
//            NREQ requesters, with a watchdog that turns a hung op into an error.
// Revision : 1.0 - initial release
// ============================================================================
module fadd_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 fu_valid,
    input  logic                 fu_ready,
    output logic [31:0]          fu_a,
    output logic [31:0]          fu_b,
    input  logic                 fu_resp_valid,
    input  logic [31:0]          fu_resp_s,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_s,
    output logic                 resp_err,
    output logic [7:0]           stale_cnt
);

    localparam logic [31:0] C_QNAN     = 32'h7FC0_0000;
    localparam logic [7:0]  C_TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IDW-1:0]  r_last_grant;
    logic [IDW-1:0]  r_id;
    logic [IDW-1:0]  w_grant;
    logic            w_any;
    logic [31:0]     r_op_a;
    logic [31:0]     r_op_b;
    logic [31:0]     r_resp_s;
    logic            r_resp_err;
    logic [7:0]      r_timer;
    logic [7:0]      r_stale_cnt;

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
        return IDW'((int'(base) + k) % NREQ);
    endfunction

    // Scan from the farthest candidate down so the nearest one after last_grant wins.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[rr_index(r_last_grant, k)]) begin
                w_grant = rr_index(r_last_grant, k);
                w_any   = 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    req_ready[w_grant] = 1'b1;
                    w_next             = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (fu_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fu_resp_valid || (r_timer == C_TMO_LAST)) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= IDW'(NREQ - 1);
            r_id         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_resp_s     <= '0;
            r_resp_err   <= 1'b0;
            r_timer      <= '0;
            r_stale_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && w_any) begin
                r_id   <= w_grant;
                r_op_a <= req_a[int'(w_grant)*32 +: 32];
                r_op_b <= req_b[int'(w_grant)*32 +: 32];
            end
            if ((r_state == S_ISSUE) && fu_ready) begin
                r_timer <= '0;
            end
            // A result on the timeout cycle takes priority over the error.
            if (r_state == S_WAIT) begin
                r_timer <= r_timer + 8'd1;
                if (fu_resp_valid) begin
                    r_resp_s   <= fu_resp_s;
                    r_resp_err <= 1'b0;
                end else if (r_timer == C_TMO_LAST) begin
                    r_resp_s   <= C_QNAN;
                    r_resp_err <= 1'b1;
                end
            end
            if ((r_state == S_RESP) && resp_ready) begin
                r_last_grant <= r_id;
            end
            if (fu_resp_valid && (r_state != S_WAIT) && (r_stale_cnt != 8'hFF)) begin
                r_stale_cnt <= r_stale_cnt + 8'd1;
            end
        end
    end

    assign fu_valid   = (r_state == S_ISSUE);
    assign fu_a       = r_op_a;
    assign fu_b       = r_op_b;
    assign resp_valid = (r_state == S_RESP);
    assign resp_id    = r_id;
    assign resp_s     = r_resp_s;
    assign resp_err   = r_resp_err;
    assign stale_cnt  = r_stale_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fadd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fadd_arbiter
// Brief    : Directed self-checking bench for fadd_arbiter (NREQ=4, TIMEOUT=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fadd_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              fu_valid;
    logic              fu_ready;
    logic [31:0]       fu_a;
    logic [31:0]       fu_b;
    logic              fu_resp_valid;
    logic [31:0]       fu_resp_s;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [31:0]       resp_s;
    logic              resp_err;
    logic [7:0]        stale_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fadd_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(64)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_a(fu_a), .fu_b(fu_b),
        .fu_resp_valid(fu_resp_valid), .fu_resp_s(fu_resp_s),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_s(resp_s), .resp_err(resp_err), .stale_cnt(stale_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] opa(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction
    function automatic logic [31:0] opb(input int i);
        return 32'h2000_0000 + 32'(i);
    endfunction
    function automatic logic [31:0] sum(input int i);
        return 32'h3000_0000 + 32'(i);
    endfunction

    task automatic set_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = opa(i);
            req_b[32*i +: 32] = opb(i);
        end
    endtask

    // Full transaction from a grant cycle in IDLE; adder answers on WAIT cycle dly.
    task automatic do_op(input int g, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] s, input int dly);
        check("grant", 32'(req_ready), 32'(1 << g));
        tick();
        check("issue_req_ready", 32'(req_ready), 32'd0);
        check("fu_valid", 32'(fu_valid), 32'd1);
        check("fu_a", fu_a, ea);
        check("fu_b", fu_b, eb);
        fu_ready = 1'b1;
        tick();
        fu_ready = 1'b0;
        check("wait_fu_valid", 32'(fu_valid), 32'd0);
        repeat (dly - 1) tick();
        check("wait_no_resp", 32'(resp_valid), 32'd0);
        fu_resp_s     = s;
        fu_resp_valid = 1'b1;
        tick();
        fu_resp_valid = 1'b0;
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_id", 32'(resp_id), 32'(g));
        check("resp_s", resp_s, s);
        check("resp_err", 32'(resp_err), 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("resp_done", 32'(resp_valid), 32'd0);
    endtask

    task automatic enter_wait(input logic [NREQ-1:0] vld, input int g);
        req_valid = vld;
        #1;
        check("grant", 32'(req_ready), 32'(1 << g));
        tick();
        req_valid = '0;
        fu_ready  = 1'b1;
        tick();
        fu_ready  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_fu_valid"}, 32'(fu_valid), 32'd0);
        check({tag, "_fu_a"}, fu_a, 32'd0);
        check({tag, "_fu_b"}, fu_b, 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_id"}, 32'(resp_id), 32'd0);
        check({tag, "_resp_s"}, resp_s, 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check({tag, "_stale"}, 32'(stale_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        fu_ready = 1'b0; fu_resp_valid = 1'b0; fu_resp_s = '0; resp_ready = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Single request: 1.0 + 2.0, adder answers five cycles into WAIT.
        req_a[31:0] = 32'h3F80_0000;
        req_b[31:0] = 32'h4000_0000;
        req_valid   = 4'b0001;
        #1;
        do_op(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5);
        req_valid = '0;
        tick();

        // Round robin from reset: grants 0,1,2,3,0 with all requesters active.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_ops();
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            do_op(k % NREQ, opa(k % NREQ), opb(k % NREQ), sum(k % NREQ), 1);
        end
        req_valid = '0;

        // Back-pressure on both sides; others keep requesting to expose a stray grant.
        req_valid = 4'b0100;
        #1;
        check("bp_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'hF;
        for (int i = 0; i < 10; i++) begin
            check("bp_fu_valid", 32'(fu_valid), 32'd1);
            check("bp_fu_a", fu_a, opa(2));
            check("bp_fu_b", fu_b, opb(2));
            check("bp_issue_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        fu_ready = 1'b1;
        tick();
        fu_ready      = 1'b0;
        fu_resp_s     = sum(2);
        fu_resp_valid = 1'b1;
        tick();
        fu_resp_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_id", 32'(resp_id), 32'd2);
            check("bp_resp_s", resp_s, sum(2));
            check("bp_resp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp_done", 32'(resp_valid), 32'd0);

        // Timeout: 64 WAIT cycles with no answer, then a late stale result.
        enter_wait(4'b0001, 0);
        repeat (63) tick();
        check("tmo_not_early", 32'(resp_valid), 32'd0);
        tick();
        check("tmo_resp_valid", 32'(resp_valid), 32'd1);
        check("tmo_resp_id", 32'(resp_id), 32'd0);
        check("tmo_resp_s", resp_s, 32'h7FC0_0000);
        check("tmo_resp_err", 32'(resp_err), 32'd1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        fu_resp_s     = 32'hDEAD_BEEF;
        fu_resp_valid = 1'b1;
        tick();
        fu_resp_valid = 1'b0;
        check("tmo_stale", 32'(stale_cnt), 32'd1);
        check("tmo_stale_no_resp", 32'(resp_valid), 32'd0);

        // Result on the timeout cycle wins over the error.
        enter_wait(4'b0001, 0);
        repeat (63) tick();
        fu_resp_s     = 32'h1234_5678;
        fu_resp_valid = 1'b1;
        tick();
        fu_resp_valid = 1'b0;
        check("sim_resp_valid", 32'(resp_valid), 32'd1);
        check("sim_resp_s", resp_s, 32'h1234_5678);
        check("sim_resp_err", 32'(resp_err), 32'd0);
        check("sim_stale", 32'(stale_cnt), 32'd1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        fu_resp_valid = 1'b1;
        tick();
        fu_resp_valid = 1'b0;
        check("idle_stale", 32'(stale_cnt), 32'd2);
        check("idle_stale_no_resp", 32'(resp_valid), 32'd0);

        // Reset in the middle of WAIT drops the op; its result arrives stale.
        enter_wait(4'b0010, 1);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_all_zero("midrst");
        fu_resp_s     = sum(1);
        fu_resp_valid = 1'b1;
        tick();
        fu_resp_valid = 1'b0;
        check("midrst_stale", 32'(stale_cnt), 32'd1);
        check("midrst_no_resp", 32'(resp_valid), 32'd0);
        req_valid = 4'hF;
        #1;
        do_op(0, opa(0), opb(0), sum(0), 2);
        req_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
